// File: rtl/mem_stall_resp.sv
// Slow word-wide data memory with a stall/done handshake.
// One request at a time is accepted in IDLE and completes LATENCY cycles later.
module mem_stall_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        busy,
  output logic        err
);

  localparam int         WORDS    = 2 ** DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [15:0]             data_out_q, data_out_d;
  logic                    run_q;

  logic [15:0]             mem [WORDS];

  logic                    req, legal, enter_resp, acc_wr;
  logic [DEPTH_LOG2-1:0]   req_idx, acc_idx;
  logic [15:0]             acc_wdata;
  logic                    unused_addr_hi;

  assign req            = rd | wr;
  assign legal          = (rd ^ wr) & ~addr[0];
  assign req_idx        = addr[DEPTH_LOG2:1];
  assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    enter_resp = 1'b0;
    acc_wr     = op_wr_q;
    acc_idx    = idx_q;
    acc_wdata  = wdata_q;
    case (state_q)
      S_IDLE: begin
        // run_q keeps a request from being accepted (and written) while held in reset
        if (legal && run_q) begin
          op_wr_d = wr;
          idx_d   = req_idx;
          wdata_d = data_in;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
            acc_wr     = wr;
            acc_idx    = req_idx;
            acc_wdata  = data_in;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp && !acc_wr) data_out_d = mem[acc_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 16'd0;
      data_out_q <= 16'd0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      run_q      <= 1'b1;
    end
  end

  // Array is deliberately not reset; an aborted write never reaches the RESP edge.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_wr) mem[acc_idx] <= acc_wdata;
  end

  assign data_out = data_out_q;
  assign done     = (state_q == S_RESP);
  assign busy     = (state_q != S_IDLE);
  assign stall    = req & ~done;
  assign err      = (state_q == S_IDLE) & req & ~legal;

endmodule

// File: tb/tb_mem_stall_resp.sv
// Bench for mem_stall_resp: directed table, corner sequences, random ops vs a word-array model.
module tb_mem_stall_resp;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'd0, data_in = 16'd0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [15:0] data_out;
  logic        done, stall, busy, err;

  logic [15:0] addr1 = 16'd0, data_in1 = 16'd0;
  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [15:0] data_out1;
  logic        done1, stall1, busy1, err1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = -100;

  logic [15:0] ref_mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stall_resp #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .done(done), .stall(stall), .busy(busy), .err(err));

  mem_stall_resp #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr1), .data_in(data_in1), .rd(rd1), .wr(wr1),
    .data_out(data_out1), .done(done1), .stall(stall1), .busy(busy1), .err(err1));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic        chk_data;
    logic [15:0] exp_data;
    logic        b2b;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % 1024;
  endfunction

  // Caller is at a negedge; returns at the negedge of the IDLE cycle after completion.
  task automatic do_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic exp_err, input logic chk_data, input logic [15:0] exp_data,
                        input logic b2b);
    int k;
    rd = r; wr = w; addr = a; data_in = d;
    #1;
    chk("err_idle", err, exp_err);
    chk("busy_idle", busy, 1'b0);
    chk("stall_req", stall, r | w);
    if (exp_err) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("err_done", done, 1'b0);
        chk("err_busy", busy, 1'b0);
        chk("err_held", err, 1'b1);
      end
    end else begin
      if (b2b) chk("accept_spacing", 16'(cyc + 1 - last_acc), 16'(LAT + 1));
      last_acc = cyc + 1;
      k = 0;
      while (k < 20) begin
        @(negedge clk);
        k++;
        if (done) break;
        chk("stall_wait", stall, 1'b1);
        chk("busy_wait", busy, 1'b1);
      end
      chk("latency", 16'(k), 16'(LAT));
      chk("stall_at_done", stall, 1'b0);
      if (chk_data) chk("rdata", data_out, exp_data);
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("busy_after", busy, 1'b0);
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input logic e, input logic cd,
                              input logic [15:0] ed, input logic b);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
    v.exp_err = e; v.chk_data = cd; v.exp_data = ed; v.b2b = b;
    return v;
  endfunction

  initial begin
    logic r, w, e, cd;
    logic [15:0] a, d;
    int idx;

    // reset state
    #2;
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout", data_out, 16'h0000);
    chk("rst_stall", stall, 1'b0);
    chk("rst_err", err, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);

    vecs.push_back(mk(0, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h1234, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 16'h0002, 16'h5678, 0, 0, 16'h0000, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 1));
    vecs.push_back(mk(1, 0, 16'h0002, 16'h0000, 0, 1, 16'h5678, 1));
    vecs.push_back(mk(0, 1, 16'h0004, 16'hCAFE, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 16'h0004, 16'h0BAD, 1, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0005, 16'h0000, 1, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 16'h0005, 16'h0BAD, 1, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0004, 16'h0000, 0, 1, 16'hCAFE, 0));
    vecs.push_back(mk(0, 1, 16'h0802, 16'hA5A5, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0002, 16'h0000, 0, 1, 16'hA5A5, 0));
    vecs.push_back(mk(0, 1, 16'h0020, 16'h0001, 0, 0, 16'h0000, 0));

    foreach (vecs[i]) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
             vecs[i].chk_data, vecs[i].exp_data, vecs[i].b2b);
      if (!vecs[i].exp_err && vecs[i].wr) ref_mem[widx(vecs[i].addr)] = vecs[i].wdata;
    end
    chk("dout_hold", data_out, 16'hA5A5);

    // reset during WAIT of a write aborts it
    rd = 1'b0; wr = 1'b1; addr = 16'h0020; data_in = 16'hFFFF;
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_dout", data_out, 16'h0000);
    chk("mid_rst_err", err, 1'b0);
    wr = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    do_req(1, 0, 16'h0020, 16'h0000, 0, 1, 16'h0001, 0);

    // LATENCY=1 instance
    wr1 = 1'b1; addr1 = 16'h0006; data_in1 = 16'h7777;
    @(negedge clk);
    chk("l1_wr_done", done1, 1'b1);
    chk("l1_wr_busy", busy1, 1'b1);
    wr1 = 1'b0;
    @(negedge clk);
    chk("l1_wr_busy_end", busy1, 1'b0);
    rd1 = 1'b1;
    #1;
    chk("l1_stall", stall1, 1'b1);
    @(negedge clk);
    chk("l1_rd_done", done1, 1'b1);
    chk("l1_rd_data", data_out1, 16'h7777);
    chk("l1_rd_stall", stall1, 1'b0);
    rd1 = 1'b0;
    @(negedge clk);
    chk("l1_rd_done_end", done1, 1'b0);
    chk("l1_rd_busy_end", busy1, 1'b0);

    // random ops against the word-array model
    for (int n = 0; n < 60; n++) begin
      a = 16'(($urandom_range(0, 3) << 11) | ($urandom_range(0, 15) << 1));
      if ($urandom_range(0, 5) == 0) a[0] = 1'b1;
      d = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       begin r = 1'b1; w = 1'b1; end
        1, 2, 3: begin r = 1'b0; w = 1'b1; end
        default: begin r = 1'b1; w = 1'b0; end
      endcase
      idx = widx(a);
      if (r && !w && !a[0] && !ref_mem.exists(idx)) begin r = 1'b0; w = 1'b1; end
      e  = (r & w) | ((r | w) & a[0]);
      cd = r & ~w & ~e;
      do_req(r, w, a, d, e, cd, cd ? ref_mem[idx] : 16'h0000, 0);
      if (w && !r && !e) ref_mem[idx] = d;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
